// File: rtl/awg_seq_pkg.sv
// Shared definitions for the AWG instruction sequencer.
// Contents: opcode encodings, JUMP field bit positions and the sequencer state type.
// The opcode always sits in the top three bits of the instruction word. Its position
// depends on INSTR_W, so the sequencer computes it locally.
package awg_seq_pkg;

  localparam int unsigned OpW = 3;

  localparam logic [OpW-1:0] OpSegment = 3'b101;
  localparam logic [OpW-1:0] OpJump    = 3'b111;
  localparam logic [OpW-1:0] OpEnd     = 3'b001;

  // JUMP operand fields, counted from bit 0 of the instruction word
  localparam int unsigned JmpTgtLsb   = 64;
  localparam int unsigned JmpTgtMsb   = 95;
  localparam int unsigned JmpIdxLsb   = 32;
  localparam int unsigned JmpIdxMsb   = 47;
  localparam int unsigned JmpTimesLsb = 0;
  localparam int unsigned JmpTimesMsb = 15;
  localparam int unsigned JmpIdxW     = JmpIdxMsb - JmpIdxLsb + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StWaitGen,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/instr_sequencer_pf_if.sv
// Bus bundle between the sequencer, instruction memory and descriptor generator.
// Signals:
//   rd_addr, rd_req          sequencer -> memory   read request (one-cycle pulse)
//   rd_valid, rd_data        memory -> sequencer   read response (one per request)
//   seg_instr, seg_valid     sequencer -> generator segment hand-off
//   generate_done            generator -> sequencer current segment consumed
// Modports:
//   master  sequencer side
//   slave   memory and generator side
interface instr_sequencer_pf_if #(
  parameter int unsigned INSTR_W = 128,
  parameter int unsigned ADDR_W  = 32
);

  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_req;
  logic               rd_valid;
  logic [INSTR_W-1:0] rd_data;
  logic [INSTR_W-1:0] seg_instr;
  logic               seg_valid;
  logic               generate_done;

  modport master (
    output rd_addr, rd_req, seg_instr, seg_valid,
    input  rd_valid, rd_data, generate_done
  );

  modport slave (
    input  rd_addr, rd_req, seg_instr, seg_valid,
    output rd_valid, rd_data, generate_done
  );

endinterface

// File: rtl/seq_loop_cnt.sv
// Loop counter bank for JUMP instructions.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr_i      clear every counter (sequence start)
//   eval_i     a JUMP is being executed this cycle; apply the increment or clear
//   idx_i      counter index taken from the JUMP word
//   times_i    iteration count, already truncated to CNT_W
//   idx_ok_o   idx_i selects an existing counter
//   take_o     the jump is taken (infinite loop, or counter below times)
// The outputs are combinational so the sequencer can choose the next pc in the same cycle.
module seq_loop_cnt
  import awg_seq_pkg::*;
#(
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               eval_i,
  input  logic [JmpIdxW-1:0] idx_i,
  input  logic [CNT_W-1:0]   times_i,
  output logic               idx_ok_o,
  output logic               take_o
);

  localparam int unsigned IdxW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  logic [CNT_W-1:0] cnt_q [NUM_CNT];
  logic [CNT_W-1:0] cnt_d [NUM_CNT];
  logic [IdxW-1:0]  sel;
  logic [CNT_W-1:0] cur;
  logic             infinite;

  assign sel      = idx_i[IdxW-1:0];
  assign idx_ok_o = 32'(idx_i) < NUM_CNT;
  assign cur      = idx_ok_o ? cnt_q[sel] : '0;
  assign infinite = (times_i == '0);
  assign take_o   = infinite || (cur < times_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '{default: '0};
    end else if (eval_i && idx_ok_o && !infinite) begin
      // Count iterations while looping; clear on exit so an enclosing loop can re-enter
      cnt_d[sel] = (cur < times_i) ? cur + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_sequencer_pf.sv
// AWG instruction sequencer with one-deep prefetch.
// Walks instruction memory from start_addr, hands SEGMENT words to the descriptor
// generator, runs JUMP loops on indexed counters and stops on END. While the generator
// consumes a segment, the next word is prefetched into pbuf.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         pulse; begin at start_addr (ignored while busy)
//   stop          abort; outstanding read is drained first
//   start_addr    first instruction byte address
//   bus           memory read and segment hand-off signals (master side)
//   busy          not idle
//   err, err_addr sticky error flag and address of the faulting instruction
module instr_sequencer_pf
  import awg_seq_pkg::*;
#(
  parameter int unsigned INSTR_W = 128,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_CNT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   start_addr,
  instr_sequencer_pf_if.master bus,
  output logic                busy,
  output logic                err,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam logic [ADDR_W-1:0] AddrStep = ADDR_W'(INSTR_W / 8);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ibuf_q, ibuf_d;
  logic [INSTR_W-1:0] pbuf_q, pbuf_d;
  logic               pbuf_v_q, pbuf_v_d;
  logic               pend_q, pend_d;
  logic               rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               seg_valid_q, seg_valid_d;
  logic [INSTR_W-1:0] seg_instr_q, seg_instr_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;

  logic [OpW-1:0]     opcode;
  logic [ADDR_W-1:0]  jmp_tgt;
  logic [CNT_W-1:0]   jmp_times;
  logic [ADDR_W-1:0]  pc_next;
  logic               cnt_clr;
  logic               cnt_eval;
  logic               idx_ok;
  logic               take;

  assign opcode    = ibuf_q[INSTR_W-1 -: OpW];
  assign jmp_tgt   = ADDR_W'(ibuf_q[JmpTgtMsb:JmpTgtLsb]);
  assign jmp_times = CNT_W'(ibuf_q[JmpTimesMsb:JmpTimesLsb]);
  assign pc_next   = pc_q + AddrStep;

  seq_loop_cnt #(
    .NUM_CNT (NUM_CNT),
    .CNT_W   (CNT_W)
  ) u_loop_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .eval_i   (cnt_eval),
    .idx_i    (ibuf_q[JmpIdxMsb:JmpIdxLsb]),
    .times_i  (jmp_times),
    .idx_ok_o (idx_ok),
    .take_o   (take)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ibuf_d      = ibuf_q;
    pbuf_d      = pbuf_q;
    pbuf_v_d    = pbuf_v_q;
    pend_d      = pend_q && !bus.rd_valid;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    seg_valid_d = 1'b0;
    seg_instr_d = seg_instr_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    cnt_clr     = 1'b0;
    cnt_eval    = 1'b0;

    if (state_q != StIdle && stop) begin
      // Stop wins over everything else; a read still in flight must be absorbed
      pbuf_v_d = 1'b0;
      state_d  = (pend_q && !bus.rd_valid) ? StDrain : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_d     = 1'b0;
            cnt_clr   = 1'b1;
            pc_d      = start_addr;
            rd_req_d  = 1'b1;
            rd_addr_d = start_addr;
            pend_d    = 1'b1;
            pbuf_v_d  = 1'b0;
            state_d   = StFetch;
          end
        end

        StFetch: begin
          if (bus.rd_valid) begin
            ibuf_d  = bus.rd_data;
            state_d = StDecode;
          end
        end

        StDecode: begin
          case (opcode)
            OpSegment: begin
              seg_instr_d = ibuf_q;
              seg_valid_d = 1'b1;
              pc_d        = pc_next;
              rd_req_d    = 1'b1;
              rd_addr_d   = pc_next;
              pend_d      = 1'b1;
              state_d     = StWaitGen;
            end
            OpJump: begin
              if (idx_ok) begin
                cnt_eval  = 1'b1;
                pc_d      = take ? jmp_tgt : pc_next;
                rd_req_d  = 1'b1;
                rd_addr_d = pc_d;
                pend_d    = 1'b1;
                state_d   = StFetch;
              end else begin
                err_d      = 1'b1;
                err_addr_d = pc_q;
                state_d    = StIdle;
              end
            end
            OpEnd: begin
              state_d = StIdle;
            end
            default: begin
              err_d      = 1'b1;
              err_addr_d = pc_q;
              state_d    = StIdle;
            end
          endcase
        end

        StWaitGen: begin
          if (bus.generate_done) begin
            if (pbuf_v_q) begin
              ibuf_d   = pbuf_q;
              pbuf_v_d = 1'b0;
              state_d  = StDecode;
            end else if (bus.rd_valid) begin
              // Prefetch lands in the same cycle: bypass pbuf
              ibuf_d  = bus.rd_data;
              state_d = StDecode;
            end else begin
              state_d = StFetch;
            end
          end else if (bus.rd_valid) begin
            pbuf_d   = bus.rd_data;
            pbuf_v_d = 1'b1;
          end
        end

        StDrain: begin
          if (bus.rd_valid) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      ibuf_q      <= '0;
      pbuf_q      <= '0;
      pbuf_v_q    <= 1'b0;
      pend_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      seg_valid_q <= 1'b0;
      seg_instr_q <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ibuf_q      <= ibuf_d;
      pbuf_q      <= pbuf_d;
      pbuf_v_q    <= pbuf_v_d;
      pend_q      <= pend_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      seg_valid_q <= seg_valid_d;
      seg_instr_q <= seg_instr_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.seg_valid = seg_valid_q;
  assign bus.seg_instr = seg_instr_q;
  assign busy          = (state_q != StIdle);
  assign err           = err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: doc/instr_sequencer_pf.md
Name: instr_sequencer_pf

Overview:
- Parametrised successor to the AWG instruction fetch/sequencer.
- Walks instruction memory from a start address and hands SEGMENT instructions to the descriptor generator.
- Executes JUMP loops on indexed counters and stops on END.
- New versus the previous generation: one-deep prefetch that overlaps fetch with generation; END opcode; infinite-loop jumps; illegal-opcode and bad-index error reporting; stop honoured at any point.

Parameters:
- INSTR_W, 128: instruction width; minimum 128, multiple of 8.
- ADDR_W, 32: byte address width.
- NUM_CNT, 8: number of loop counters.
- CNT_W, 16: loop counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  pulse; begin sequencing at start_addr.
- stop  in  1  level or pulse; abort sequencing.
- start_addr  in  ADDR_W  first instruction byte address.
- rd_addr  out  ADDR_W  read address; valid while rd_req is high.
- rd_req  out  1  one-cycle read request pulse.
- rd_valid  in  1  read data valid; exactly one per rd_req, latency ≥1 cycle.
- rd_data  in  INSTR_W  instruction word.
- generate_done  in  1  pulse; current segment consumed.
- seg_instr  out  INSTR_W  segment instruction; held stable until next seg_valid.
- seg_valid  out  1  one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky error flag; cleared by start or rst.
- err_addr  out  ADDR_W  address of the faulting instruction.

Behaviour:
- Reset: single clock clk; reset rst is synchronous, active-high. On reset: rd_req, seg_valid, busy, err = 0; rd_addr, err_addr, seg_instr = 0; all counters = 0; state IDLE.
- Opcode field [INSTR_W-1:INSTR_W-3]:
  - SEGMENT = 3'b101.
  - JUMP = 3'b111, with fields target [95:64], counter index [47:32], times [15:0]. Target is truncated or zero-extended to ADDR_W; times is truncated to CNT_W.
  - END = 3'b001.
  - Any other opcode is illegal.
- Address step: ADDR_STEP = INSTR_W/8. pc advances pc+ADDR_STEP modulo 2^ADDR_W; wrap is silent.
- States:
  - IDLE: on start, clear err and counters, set pc=start_addr, issue rd_req, go FETCH.
  - FETCH: on rd_valid, latch word into ibuf, go DECODE.
  - DECODE (1 cycle):
    - SEGMENT: seg_instr<=ibuf, seg_valid=1 next cycle; pc+=STEP; issue prefetch rd_req at new pc; go WAIT_GEN.
    - JUMP: idx<NUM_CNT required. times==0 → pc=target (infinite, counter untouched). Else if cnt[idx]<times → cnt[idx]++, pc=target. Else cnt[idx]=0, pc+=STEP. Then issue rd_req, go FETCH.
    - END: go IDLE.
    - Illegal opcode or idx≥NUM_CNT: err=1, err_addr=pc, go IDLE.
  - WAIT_GEN: on prefetch rd_valid, store word in pbuf and set pbuf_v=1. On generate_done:
    - pbuf_v=1 → move pbuf to ibuf, go DECODE.
    - pbuf_v=0 → go FETCH; the outstanding read completes there.
    - generate_done and rd_valid in the same cycle: word goes straight to ibuf, then DECODE.
  - DRAIN: wait for the outstanding rd_valid, discard it, go IDLE.
- Cycle costs:
  - start to first seg_valid: read latency + 3 cycles.
  - generate_done to next seg_valid with prefetch hit: 2 cycles.
  - Each taken jump: one refetch.
- Only one read is ever outstanding. rd_req is never issued while a read is pending.
- stop (any state except IDLE): no further seg_valid and no new rd_req. If a read is outstanding → DRAIN, else → IDLE. stop has priority over generate_done and rd_valid in the same cycle.
- start while busy: ignored.
- Counters are cleared on start. A counter is cleared when its loop exits.

Decomposition:
- Shared package awg_seq_pkg holds:
  - opcode constants;
  - field bit-position constants;
  - state encoding localparams.
- Sub-module seq_loop_cnt:
  - NUM_CNT×CNT_W counter array;
  - index check;
  - take/exit decision;
  - increment/clear.

Test Plan:
1. start_addr=0x100; memory holds SEG, SEG, END; read latency 2; generate_done 5 cycles after each seg_valid → two seg_valid pulses, rd_addr sequence 0x100, 0x110, 0x120; busy drops after END; err=0.
2. Memory 0x0 SEG, 0x10 JUMP(target=0x0, idx=3, times=2), 0x20 END → 3 seg_valid pulses; cnt[3] ends at 0; rd_addr sequence 0x0, 0x10, 0x0, 0x10, 0x0, 0x10, 0x20.
3. Nested loops: inner JUMP idx=0 times=1, outer JUMP idx=1 times=1, single SEG body → exactly 4 seg_valid pulses; counters independent.
4. Opcode 3'b010 at 0x30 → err=1, err_addr=0x30, busy=0, no seg_valid; next start clears err.
5. JUMP with idx=9 (NUM_CNT=8) → err=1. Separately, JUMP with times=0 loops forever until stop is asserted.
6. stop while prefetch is outstanding in WAIT_GEN → DRAIN consumes rd_valid, no seg_valid, IDLE next cycle. rst mid-fetch → all outputs at reset values next cycle.
